branch_predictor: RTL and testbench

Fetch-stage conditional-branch direction predictor. It is the producing end of the branch-resolution path: it issues a taken/not-taken prediction for the instruction at PCF. It then consumes the resolved outcome of B-type instructions in Execute to train a table of 2-bit saturating counters and to flag mispredictions. It sits between the fetch PC mux and the Execute-stage resolution logic. The prediction and table index travel down the pipeline registers alongside the instruction.

---
 rtl/branch_predictor.sv | 87 ++++++++
 tb/tb_branch_predictor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage 2-bit saturating-counter direction predictor.
// Optional GSHARE_EN macro adds a global history register XORed into the index.
module branch_predictor #(
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           PCF,
  output logic                  PCSrcPredF,
  output logic [INDEX_BITS-1:0] PredIdxF,
  input  logic [1:0]            BranchOpE,
  input  logic                  PCSrcResE,
  input  logic                  PCSrcPredE,
  input  logic [INDEX_BITS-1:0] PredIdxE,
  input  logic                  StallE,
  output logic                  MispredictE
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [1:0] ctr [DEPTH];
  logic       upd;
  logic       isbr;
  logic [1:0] cur;
  logic [1:0] nxt;

  logic unused_pc;
  assign unused_pc = ^{PCF[31:INDEX_BITS+2], PCF[1:0]};

`ifdef GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;

  // Global history shifts in resolved outcomes on training edges only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd) begin
      ghr <= {ghr[INDEX_BITS-2:0], PCSrcResE};
    end
  end

  // Hash PC with history to pick the counter.
  always_comb begin
    PredIdxF = PCF[INDEX_BITS+1:2] ^ ghr;
  end
`else
  // Pure PC-indexed lookup.
  always_comb begin
    PredIdxF = PCF[INDEX_BITS+1:2];
  end
`endif

  // Direction is the counter MSB; no bypass from the write port.
  always_comb begin
    PCSrcPredF = ctr[PredIdxF][1];
  end

  // Train only resolved B-types; jumps still flag direction mistakes.
  always_comb begin
    upd         = (BranchOpE == 2'b11) && !StallE;
    isbr        = (BranchOpE == 2'b11) || (BranchOpE == 2'b01);
    MispredictE = isbr && (PCSrcPredE != PCSrcResE);
  end

  // Saturating increment/decrement of the trained counter.
  always_comb begin
    cur = ctr[PredIdxE];
    nxt = cur;
    unique case (1'b1)
      PCSrcResE && (cur != 2'b11):  nxt = cur + 2'd1;
      !PCSrcResE && (cur != 2'b00): nxt = cur - 2'd1;
      default:                      nxt = cur;
    endcase
  end

  // Counter table; every entry resets to weak not-taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr[i] <= 2'b01;
      end
    end else if (upd) begin
      ctr[PredIdxE] <= nxt;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized plus directed bench for branch_predictor.
// Reference model keeps counters as integers clamped to 0..3.
module tb_branch_predictor;

  localparam int IB = 6;
  localparam int N  = 1 << IB;

  logic          clk = 0;
  logic          reset;
  logic [31:0]   PCF;
  logic          PCSrcPredF;
  logic [IB-1:0] PredIdxF;
  logic [1:0]    BranchOpE;
  logic          PCSrcResE;
  logic          PCSrcPredE;
  logic [IB-1:0] PredIdxE;
  logic          StallE;
  logic          MispredictE;

  int nchk = 0;
  int nfail = 0;
  int tbl [N];
  int hist;
  logic last_mis;

  branch_predictor #(.INDEX_BITS(IB)) dut (
    .clk(clk),
    .reset(reset),
    .PCF(PCF),
    .PCSrcPredF(PCSrcPredF),
    .PredIdxF(PredIdxF),
    .BranchOpE(BranchOpE),
    .PCSrcResE(PCSrcResE),
    .PCSrcPredE(PCSrcPredE),
    .PredIdxE(PredIdxE),
    .StallE(StallE),
    .MispredictE(MispredictE)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void mreset();
    for (int i = 0; i < N; i++) tbl[i] = 1;
    hist = 0;
  endfunction

  function automatic int midx(logic [31:0] pc);
`ifdef GSHARE_EN
    return ((pc >> 2) % N) ^ hist;
`else
    return (pc >> 2) % N;
`endif
  endfunction

  function automatic logic [31:0] pc_for(int idx);
`ifdef GSHARE_EN
    return 32'((idx ^ hist) * 4);
`else
    return 32'(idx * 4);
`endif
  endfunction

  // One pipeline cycle: drive, check combinational outputs, then clock.
  task automatic cycle(logic [31:0] pc, logic [1:0] op, logic res,
                       logic pe, int idx, logic stall);
    int pi;
    logic em;
    @(negedge clk);
    PCF = pc;
    BranchOpE = op;
    PCSrcResE = res;
    PCSrcPredE = pe;
    PredIdxE = IB'(idx);
    StallE = stall;
    #1;
    pi = midx(pc);
    em = (op == 2'b11 || op == 2'b01) && (pe != res);
    check("idx", 32'(PredIdxF), 32'(pi));
    check("pred", 32'(PCSrcPredF), 32'(tbl[pi] >= 2));
    check("mis", 32'(MispredictE), 32'(em));
    last_mis = MispredictE;
    @(posedge clk);
    if (op == 2'b11 && !stall) begin
      if (res) tbl[idx] = (tbl[idx] == 3) ? 3 : tbl[idx] + 1;
      else     tbl[idx] = (tbl[idx] == 0) ? 0 : tbl[idx] - 1;
      hist = ((hist << 1) | int'(res)) % N;
    end
  endtask

  task automatic upd(int idx, logic res);
    cycle(32'h0, 2'b11, res, 1'b0, idx, 1'b0);
  endtask

  task automatic probe(string tag, int idx, logic exp);
    @(negedge clk);
    PCF = pc_for(idx);
    BranchOpE = 2'b00;
    StallE = 1'b0;
    #1;
    check(tag, 32'(PCSrcPredF), 32'(exp));
    @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1;
    mreset();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1;
    PCF = 32'h40;
    BranchOpE = 2'b00;
    PCSrcResE = 0;
    PCSrcPredE = 0;
    PredIdxE = '0;
    StallE = 0;
    mreset();
    #12;
    check("rst_pred", 32'(PCSrcPredF), 32'd0);
    check("rst_idx", 32'(PredIdxF), 32'h10);
    reset = 0;
    probe("post_rst_pred", 16, 1'b0);

    upd(16, 1);
    probe("sat_t_first", 16, 1'b1);
    upd(16, 1);
    upd(16, 1);
    upd(16, 0);
    probe("sat_t_11_to_10", 16, 1'b1);

    upd(5, 0);
    upd(5, 0);
    upd(5, 0);
    upd(5, 1);
    probe("sat_nt_floor", 5, 1'b0);

    cycle(32'h0, 2'b11, 1'b0, 1'b1, 40, 1'b0);
    check("mis_btype", 32'(last_mis), 32'd1);
    cycle(32'h0, 2'b01, 1'b1, 1'b0, 32, 1'b0);
    check("mis_jump", 32'(last_mis), 32'd1);
    probe("jump_no_train", 32, 1'b0);
    cycle(32'h0, 2'b00, 1'b0, 1'b1, 32, 1'b0);
    check("mis_masked", 32'(last_mis), 32'd0);
    cycle(32'h0, 2'b10, 1'b1, 1'b0, 32, 1'b0);
    check("mis_illegal", 32'(last_mis), 32'd0);
    probe("illegal_no_train", 32, 1'b0);

    pulse_reset();
    for (int i = 0; i < 3; i++) cycle(32'h0, 2'b11, 1'b1, 1'b0, 16, 1'b1);
    probe("stall_none", 16, 1'b0);
    cycle(32'h0, 2'b11, 1'b1, 1'b0, 16, 1'b1);
    cycle(32'h0, 2'b11, 1'b1, 1'b0, 16, 1'b0);
    probe("stall_once", 16, 1'b1);
    upd(16, 0);
    probe("stall_exact", 16, 1'b0);

    upd(16, 1);
    upd(16, 1);
    upd(16, 1);
    @(negedge clk);
    PCF = pc_for(16);
    BranchOpE = 2'b00;
    #1;
    check("pre_async", 32'(PCSrcPredF), 32'd1);
    reset = 1;
    mreset();
    #1;
    check("async_pred", 32'(PCSrcPredF), 32'd0);
    PCF = 32'h40;
    #1;
    check("async_idx", 32'(PredIdxF), 32'h10);
    reset = 0;

    for (int n = 0; n < 400; n++) begin
      logic [1:0] op;
      int r;
      r = $urandom_range(0, 9);
      op = (r < 6) ? 2'b11 : (r < 8) ? 2'b01 : (r < 9) ? 2'b00 : 2'b10;
      cycle($urandom, op, 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
